// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: bus widths and FSM state encodings.
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_BUSY = 2'b01,
    D_BUSY = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one backing-memory port,
// one transaction at a time, with held flags so a completed port waits for the pipeline to advance.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_rdy,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rdy,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  arb_state_t state, next_state;
  logic i_held, d_held;
  logic i_pend, d_pend, advance;
  logic i_new, d_new;
  logic issue_i, issue_d;
  logic ack_i, ack_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Issue decisions see the held flags as they will be after an advance clears them,
  // so a still-asserted request is reissued in the very cycle its flag drops.
  always_comb begin
    next_state = state;
    issue_i    = 1'b0;
    issue_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_new && (!i_new || D_PRIORITY)) begin
          issue_d    = 1'b1;
          next_state = D_BUSY;
        end else if (i_new) begin
          issue_i    = 1'b1;
          next_state = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (m_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    i_pend  = i_re & ~i_held;
    d_pend  = (d_re | d_we) & ~d_held;
    i_rdy   = ~rst_n | ~i_pend;
    d_rdy   = ~rst_n | ~d_pend;
    advance = i_rdy & d_rdy;
    i_new   = i_re & ~(i_held & ~advance);
    d_new   = (d_re | d_we) & ~(d_held & ~advance);
    ack_i   = (state == I_BUSY) & m_ack;
    ack_d   = (state == D_BUSY) & m_ack;
  end

  // A completion setting a held flag takes precedence over an advance clearing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_data  <= '0;
      d_rdata <= '0;
      i_held  <= 1'b0;
      d_held  <= 1'b0;
    end else begin
      m_req <= (next_state != IDLE);
      if (issue_d) begin
        m_addr  <= d_addr;
        m_we    <= d_we;
        m_wdata <= d_wdata;
      end else if (issue_i) begin
        m_addr <= i_addr;
        m_we   <= 1'b0;
      end
      if (ack_i) i_data <= m_rdata;
      if (ack_d && !m_we) d_rdata <= m_rdata;
      if (ack_i) i_held <= 1'b1;
      else if (advance) i_held <= 1'b0;
      if (ack_d) d_held <= 1'b1;
      else if (advance) d_held <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (~advance),
    .count (stall_cnt)
  );

endmodule
